// File: rtl/sdram_arbiter.sv
// Three-port arbiter in front of a single-transaction SDRAM controller.
// The winning port's request is captured at grant and carried through issue and wait.
module sdram_arbiter #(
  parameter int RR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] p0_addr,
  input  logic [24:0] p1_addr,
  input  logic [24:0] p2_addr,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p2_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic        p2_we,
  input  logic        p0_word,
  input  logic        p1_word,
  input  logic        p2_word,
  input  logic [15:0] p0_din,
  input  logic [15:0] p1_din,
  input  logic [15:0] p2_din,
  output logic [15:0] p0_dout,
  output logic [15:0] p1_dout,
  output logic [15:0] p2_dout,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic        p2_ack,
  output logic [24:0] sd_addr,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        sd_word,
  output logic [15:0] sd_din,
  input  logic [15:0] sd_dout,
  input  logic        sd_busy,
  output logic [1:0]  gnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [24:0]      addr_q, addr_d;
  logic             word_q, word_d;
  logic [15:0]      din_q, din_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             we_q, we_d;
  logic [2:0]       ack_q, ack_d;
  logic [2:0][15:0] dout_q, dout_d;

  logic [2:0]       req;
  logic [2:0]       we_a;
  logic [2:0]       word_a;
  logic [2:0][24:0] addr_a;
  logic [2:0][15:0] din_a;
  logic [1:0]       sel;

  assign req    = {p2_req, p1_req, p0_req};
  assign we_a   = {p2_we, p1_we, p0_we};
  assign word_a = {p2_word, p1_word, p0_word};
  assign addr_a = {p2_addr, p1_addr, p0_addr};
  assign din_a  = {p2_din, p1_din, p0_din};

  // Round-robin search starts one past the last granted port (ptr_q).
  always_comb begin
    sel = 2'd0;
    if (RR != 0) begin
      case (ptr_q)
        2'd0:    sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
        2'd1:    sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
        default: sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
    end else begin
      sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    word_d  = word_q;
    din_d   = din_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    we_d    = we_q;
    ack_d   = 3'b000;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ISSUE;
          gnt_d   = sel;
          ptr_d   = sel;
          addr_d  = addr_a[sel];
          word_d  = word_a[sel];
          din_d   = din_a[sel];
          we_d    = we_a[sel];
          rd_d    = ~we_a[sel];
          wr_d    = we_a[sel];
        end
      end
      ISSUE: begin
        if (sd_busy) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // we_q remembers the direction after the strobes have dropped.
        if (!sd_busy) begin
          ack_d[gnt_q] = 1'b1;
          if (!we_q) dout_d[gnt_q] = sd_dout;
          gnt_d   = 2'd3;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q  <= 2'd3;
      ptr_q  <= 2'd2;
      addr_q <= '0;
      word_q <= 1'b0;
      din_q  <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      we_q   <= 1'b0;
      ack_q  <= 3'b000;
      dout_q <= '0;
    end else begin
      gnt_q  <= gnt_d;
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      word_q <= word_d;
      din_q  <= din_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      we_q   <= we_d;
      ack_q  <= ack_d;
      dout_q <= dout_d;
    end
  end

  assign sd_addr   = addr_q;
  assign sd_rd     = rd_q;
  assign sd_wr     = wr_q;
  assign sd_word   = word_q;
  assign sd_din    = din_q;
  assign gnt       = gnt_q;
  assign p0_ack    = ack_q[0];
  assign p1_ack    = ack_q[1];
  assign p2_ack    = ack_q[2];
  assign p0_dout   = dout_q[0];
  assign p1_dout   = dout_q[1];
  assign p2_dout   = dout_q[2];
  assign dbg_state = state_q;

endmodule
